// File: rtl/monitor_event_collector.sv
// Event pre-counting front end: saturating per-channel pre-counters drained round-robin
// over a valid/ready increment port. Define MONITOR_EVENT_EDGE_EN to count rising edges instead of levels.
module monitor_event_collector #(
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned PRE_W      = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_EVENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  inc_valid_o,
  input  logic                  inc_ready_i,
  output logic [IDX_W-1:0]      inc_idx_o,
  output logic [PRE_W-1:0]      inc_amount_o,
  output logic [NUM_EVENTS-1:0] ovf_o,
  input  logic [NUM_EVENTS-1:0] ovf_clear_i
);

  logic [PRE_W-1:0]      r_pre [NUM_EVENTS];
  logic [IDX_W-1:0]      r_rr;
  logic                  r_valid;
  logic [IDX_W-1:0]      r_idx;
  logic [PRE_W-1:0]      r_amount;
  logic [NUM_EVENTS-1:0] r_ovf;

  logic [NUM_EVENTS-1:0] w_evt;
  logic [NUM_EVENTS-1:0] w_nz;
  logic [NUM_EVENTS-1:0] w_take;
  logic [NUM_EVENTS-1:0] w_lost;
  logic                  w_any;
  logic [IDX_W-1:0]      w_grant;
  logic                  w_free;
  logic                  w_load;

`ifdef MONITOR_EVENT_EDGE_EN
  logic [NUM_EVENTS-1:0] r_hist;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hist <= '0;
    end else begin
      r_hist <= event_i;
    end
  end

  assign w_evt = {NUM_EVENTS{en_i}} & event_i & ~r_hist;
`else
  assign w_evt = {NUM_EVENTS{en_i}} & event_i;
`endif

  // Round-robin: first pass covers [rr, N-1], second pass wraps to [0, rr-1].
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      w_nz[i] = (r_pre[i] != '0);
    end
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (!w_any && w_nz[i] && (IDX_W'(i) >= r_rr)) begin
        w_any   = 1'b1;
        w_grant = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (!w_any && w_nz[i]) begin
        w_any   = 1'b1;
        w_grant = IDX_W'(i);
      end
    end
  end

  assign w_free = !r_valid || inc_ready_i;
  assign w_load = w_free && w_any && !clear_i;

  always_comb begin
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      w_take[i] = w_load && (w_grant == IDX_W'(i));
      w_lost[i] = w_evt[i] && (r_pre[i] == '1) && !w_take[i] && !clear_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        r_pre[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        if (w_take[i]) begin
          r_pre[i] <= PRE_W'(w_evt[i]);
        end else if (w_evt[i] && (r_pre[i] != '1)) begin
          r_pre[i] <= r_pre[i] + PRE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~ovf_clear_i) | w_lost;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_amount <= '0;
      r_rr     <= '0;
    end else if (clear_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_idx    <= w_grant;
      r_amount <= r_pre[w_grant];
      r_rr     <= (w_grant == IDX_W'(NUM_EVENTS - 1)) ? '0 : w_grant + IDX_W'(1);
    end else if (r_valid && inc_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign inc_valid_o  = r_valid;
  assign inc_idx_o    = r_idx;
  assign inc_amount_o = r_amount;
  assign ovf_o        = r_ovf;

endmodule
